// File: rtl/pcileech_cfgspace_arbiter_pkg.sv
// Shared types for the shadow config-space BRAM arbiter: client ids and
// the response pipe entry that follows every grant.
package pcileech_cfgspace_pkg;

  localparam int NUM_CLI = 3;

  typedef enum logic [1:0] {
    CLI_TLP = 2'd0,
    CLI_USB = 2'd1,
    CLI_INT = 2'd2
  } cli_id_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
    logic       we;
    logic [7:0] tag;
  } pipe_entry_t;

endpackage

// File: rtl/pcileech_cfgspace_arbiter_if.sv
// Client-side request/response bundle, one lane per client
// (lane 0 = TLP, 1 = USB, 2 = INT).
interface pcileech_cfgspace_arbiter_if;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  req_we;
  logic [29:0] req_addr;
  logic [11:0] req_be;
  logic [95:0] req_data;
  logic [23:0] req_tag;
  logic [2:0]  rsp_valid;
  logic        rsp_wr;
  logic [7:0]  rsp_tag;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_data, req_tag,
    input  req_ready, rsp_valid, rsp_wr, rsp_tag, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_data, req_tag,
    output req_ready, rsp_valid, rsp_wr, rsp_tag, rsp_data
  );
endinterface

// File: rtl/pcileech_cfgspace_arbiter_rsp_pipe.sv
// Fixed-depth shift register of grant records, aligned with the BRAM read
// latency so each record emerges alongside its read data.
module pcileech_cfgspace_rsp_pipe
  import pcileech_cfgspace_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  pipe_entry_t entry_in,
  output pipe_entry_t entry_out
);

  pipe_entry_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= entry_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign entry_out = stage[DEPTH-1];

endmodule

// File: rtl/pcileech_cfgspace_arbiter.sv
// Single-port-per-direction scheduler for the shadow config-space BRAM:
// TLP priority, USB/INT round-robin, and a starvation guard for USB/INT.
module pcileech_cfgspace_arbiter
  import pcileech_cfgspace_pkg::*;
#(
  parameter int RD_LAT       = 2,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  pcileech_cfgspace_arbiter_if.slave    cli,
  input  logic                          cfg_zero,
  output logic [3:0]                    bram_we,
  output logic [9:0]                    bram_wr_addr,
  output logic [31:0]                   bram_wr_data,
  output logic [9:0]                    bram_rd_addr,
  input  logic [31:0]                   bram_rd_data
);

  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  logic        rr_int;
  logic [7:0]  cnt_usb, cnt_int;
  logic [9:0]  wr_addr_q, rd_addr_q;
  logic [31:0] wr_data_q;

  logic [2:0]  gnt;
  logic        gnt_any, usb_starved, int_starved;
  cli_id_t     g_id;
  logic        g_we;
  logic [9:0]  g_addr;
  logic [3:0]  g_be;
  logic [31:0] g_data;
  logic [7:0]  g_tag;

  pipe_entry_t pipe_in, pipe_out;
  logic        rv;
  logic [2:0]  rsp_onehot;

  assign usb_starved = cli.req_valid[1] && (cnt_usb == LIM);
  assign int_starved = cli.req_valid[2] && (cnt_int == LIM);

  always_comb begin
    gnt = 3'b000;
    if (!rst)                                gnt = 3'b000;
    else if (usb_starved && int_starved)     gnt = rr_int ? 3'b100 : 3'b010;
    else if (usb_starved)                    gnt = 3'b010;
    else if (int_starved)                    gnt = 3'b100;
    else if (cli.req_valid[0])               gnt = 3'b001;
    else if (cli.req_valid[1] && cli.req_valid[2]) gnt = rr_int ? 3'b100 : 3'b010;
    else if (cli.req_valid[1])               gnt = 3'b010;
    else if (cli.req_valid[2])               gnt = 3'b100;
  end

  assign gnt_any       = |gnt;
  assign cli.req_ready = gnt;

  always_comb begin
    g_id   = CLI_TLP;
    g_we   = cli.req_we[0];
    g_addr = cli.req_addr[9:0];
    g_be   = cli.req_be[3:0];
    g_data = cli.req_data[31:0];
    g_tag  = cli.req_tag[7:0];
    if (gnt[1]) begin
      g_id   = CLI_USB;
      g_we   = cli.req_we[1];
      g_addr = cli.req_addr[19:10];
      g_be   = cli.req_be[7:4];
      g_data = cli.req_data[63:32];
      g_tag  = cli.req_tag[15:8];
    end else if (gnt[2]) begin
      g_id   = CLI_INT;
      g_we   = cli.req_we[2];
      g_addr = cli.req_addr[29:20];
      g_be   = cli.req_be[11:8];
      g_data = cli.req_data[95:64];
      g_tag  = cli.req_tag[23:16];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_int    <= 1'b0;
      cnt_usb   <= '0;
      cnt_int   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      if (gnt[1])      rr_int <= 1'b1;
      else if (gnt[2]) rr_int <= 1'b0;

      if (!cli.req_valid[1] || gnt[1]) cnt_usb <= '0;
      else if (cnt_usb != LIM)         cnt_usb <= cnt_usb + 8'd1;

      if (!cli.req_valid[2] || gnt[2]) cnt_int <= '0;
      else if (cnt_int != LIM)         cnt_int <= cnt_int + 8'd1;

      if (gnt_any && g_we) begin
        wr_addr_q <= g_addr;
        wr_data_q <= g_data;
      end
      if (gnt_any && !g_we) rd_addr_q <= g_addr;
    end
  end

  // Ports are driven in the grant cycle itself so BRAM latency equals RD_LAT.
  assign bram_we      = (gnt_any && g_we)  ? g_be   : 4'b0000;
  assign bram_wr_addr = (gnt_any && g_we)  ? g_addr : wr_addr_q;
  assign bram_wr_data = (gnt_any && g_we)  ? g_data : wr_data_q;
  assign bram_rd_addr = (gnt_any && !g_we) ? g_addr : rd_addr_q;

  assign pipe_in = '{valid: gnt_any, id: g_id, we: g_we, tag: g_tag};

  pcileech_cfgspace_rsp_pipe #(.DEPTH(RD_LAT)) u_rsp_pipe (
    .clk       (clk),
    .rst       (rst),
    .entry_in  (pipe_in),
    .entry_out (pipe_out)
  );

  assign rv = pipe_out.valid && rst;

  always_comb begin
    rsp_onehot = 3'b000;
    if (rv) begin
      case (pipe_out.id)
        2'd1:    rsp_onehot = 3'b010;
        2'd2:    rsp_onehot = 3'b100;
        default: rsp_onehot = 3'b001;
      endcase
    end
  end

  assign cli.rsp_valid = rsp_onehot;
  assign cli.rsp_wr    = rv && pipe_out.we;
  assign cli.rsp_tag   = rv ? pipe_out.tag : 8'h00;
  assign cli.rsp_data  = (rv && !pipe_out.we && !cfg_zero) ? bram_rd_data : 32'h0;

endmodule

// File: tb/tb_pcileech_cfgspace_arbiter.sv
// Directed bench for the config-space arbiter with a behavioural BRAM model.
module tb_pcileech_cfgspace_arbiter;

  localparam int RD_LAT = 2;
  localparam int LIMIT  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_zero;
  logic [3:0]  bram_we;
  logic [9:0]  bram_wr_addr, bram_rd_addr;
  logic [31:0] bram_wr_data, bram_rd_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [1024];
  logic [31:0] rdp [RD_LAT];
  logic [2:0]  exp_g [16];

  pcileech_cfgspace_arbiter_if bus ();

  pcileech_cfgspace_arbiter #(.RD_LAT(RD_LAT), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .cli          (bus),
    .cfg_zero     (cfg_zero),
    .bram_we      (bram_we),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_data (bram_wr_data),
    .bram_rd_addr (bram_rd_addr),
    .bram_rd_data (bram_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bram_we[b]) mem[bram_wr_addr][8*b +: 8] <= bram_wr_data[8*b +: 8];
    rdp[0] <= mem[bram_rd_addr];
    for (int i = 1; i < RD_LAT; i++) rdp[i] <= rdp[i-1];
  end
  assign bram_rd_data = rdp[RD_LAT-1];

  function automatic logic [31:0] memval(input int a);
    return (a == 16) ? 32'h12345678 : (32'hA5C30000 | 32'(a));
  endfunction

  function automatic logic [7:0] tag_of(input logic [2:0] oh);
    return oh[1] ? 8'h21 : (oh[2] ? 8'h32 : 8'h10);
  endfunction

  function automatic int addr_of(input logic [2:0] oh);
    return oh[1] ? 32'h200 : (oh[2] ? 32'h300 : 32'h100);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.req_valid = 3'b000;
    bus.req_we    = 3'b000;
    bus.req_be    = 12'h000;
    bus.req_data  = 96'h0;
    bus.req_addr  = {10'h300, 10'h200, 10'h100};
    bus.req_tag   = {8'h32, 8'h21, 8'h10};
  endtask

  // Holds v for n cycles of reads, then drains; checks grants and responses against exp_g.
  task automatic run_pattern(input string name, input logic [2:0] v, input int n);
    logic [2:0] e;
    for (int c = 0; c < n + RD_LAT; c++) begin
      bus.req_valid = (c < n) ? v : 3'b000;
      @(negedge clk);
      chk($sformatf("%s_ready_c%0d", name, c), 32'(bus.req_ready), (c < n) ? 32'(exp_g[c]) : 32'h0);
      e = (c >= RD_LAT) ? exp_g[c-RD_LAT] : 3'b000;
      chk($sformatf("%s_rspv_c%0d", name, c), 32'(bus.rsp_valid), 32'(e));
      if (e != 3'b000) begin
        chk($sformatf("%s_tag_c%0d", name, c), 32'(bus.rsp_tag), 32'(tag_of(e)));
        chk($sformatf("%s_data_c%0d", name, c), bus.rsp_data, memval(addr_of(e)));
      end
      next_cycle();
    end
    bus.req_valid = 3'b000;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ready"},   32'(bus.req_ready), 32'h0);
    chk({name, "_rspv"},    32'(bus.rsp_valid), 32'h0);
    chk({name, "_rspwr"},   32'(bus.rsp_wr),    32'h0);
    chk({name, "_rsptag"},  32'(bus.rsp_tag),   32'h0);
    chk({name, "_rspdata"}, bus.rsp_data,       32'h0);
    chk({name, "_we"},      32'(bram_we),       32'h0);
    chk({name, "_wraddr"},  32'(bram_wr_addr),  32'h0);
    chk({name, "_wrdata"},  bram_wr_data,       32'h0);
    chk({name, "_rdaddr"},  32'(bram_rd_addr),  32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = memval(i);
    for (int i = 0; i < RD_LAT; i++) rdp[i] = 32'h0;
    rst      = 1'b0;
    cfg_zero = 1'b0;
    idle_reqs();
    bus.req_valid = 3'b111;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk_reset_outputs("reset");
    next_cycle();
    rst = 1'b1;
    bus.req_valid = 3'b000;
    next_cycle();

    // All three valid: TLP x4, forced USB, forced INT, TLP x3, USB, INT
    exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001; exp_g[3] = 3'b001;
    exp_g[4] = 3'b010; exp_g[5] = 3'b100; exp_g[6] = 3'b001; exp_g[7] = 3'b001;
    exp_g[8] = 3'b001; exp_g[9] = 3'b010; exp_g[10] = 3'b100;
    run_pattern("starve", 3'b111, 11);

    for (int c = 0; c < 6; c++) exp_g[c] = (c % 2 == 0) ? 3'b010 : 3'b100;
    run_pattern("rr", 3'b110, 6);

    // Partial write then read-after-write on the TLP lane
    bus.req_valid = 3'b001; bus.req_we = 3'b001; bus.req_be = 12'h003;
    bus.req_addr  = {10'h300, 10'h200, 10'h010};
    bus.req_data  = {64'h0, 32'hDEADBEEF};
    bus.req_tag   = {8'h32, 8'h21, 8'h41};
    @(negedge clk);
    chk("raw_wr_ready", 32'(bus.req_ready), 32'h1);
    chk("raw_wr_we",    32'(bram_we),       32'h3);
    chk("raw_wr_addr",  32'(bram_wr_addr),  32'h010);
    chk("raw_wr_data",  bram_wr_data,       32'hDEADBEEF);
    next_cycle();
    bus.req_we = 3'b000; bus.req_be = 12'h000; bus.req_tag = {8'h32, 8'h21, 8'h42};
    @(negedge clk);
    chk("raw_rd_we",    32'(bram_we),      32'h0);
    chk("raw_rd_addr",  32'(bram_rd_addr), 32'h010);
    next_cycle();
    bus.req_valid = 3'b000;
    @(negedge clk);
    chk("raw_ack_v",    32'(bus.rsp_valid), 32'h1);
    chk("raw_ack_wr",   32'(bus.rsp_wr),    32'h1);
    chk("raw_ack_tag",  32'(bus.rsp_tag),   32'h41);
    chk("raw_ack_data", bus.rsp_data,       32'h0);
    chk("raw_hold_rd",  32'(bram_rd_addr),  32'h010);
    next_cycle();
    @(negedge clk);
    chk("raw_rd_v",     32'(bus.rsp_valid), 32'h1);
    chk("raw_rd_wr",    32'(bus.rsp_wr),    32'h0);
    chk("raw_rd_tag",   32'(bus.rsp_tag),   32'h42);
    chk("raw_rd_data",  bus.rsp_data,       32'h1234BEEF);
    next_cycle();

    // USB read with cfg_zero asserted in the response cycle
    idle_reqs();
    bus.req_valid = 3'b010; bus.req_tag = {8'h32, 8'h55, 8'h10};
    @(negedge clk);
    chk("cz_ready", 32'(bus.req_ready), 32'h2);
    next_cycle();
    bus.req_valid = 3'b000;
    next_cycle();
    cfg_zero = 1'b1;
    @(negedge clk);
    chk("cz_v",    32'(bus.rsp_valid), 32'h2);
    chk("cz_wr",   32'(bus.rsp_wr),    32'h0);
    chk("cz_tag",  32'(bus.rsp_tag),   32'h55);
    chk("cz_data", bus.rsp_data,       32'h0);
    next_cycle();
    cfg_zero = 1'b0;

    // Reset asserted while reads are in flight
    idle_reqs();
    bus.req_valid = 3'b001;
    @(negedge clk);
    chk("mr_ready_t0", 32'(bus.req_ready), 32'h1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_ready_t1", 32'(bus.req_ready), 32'h0);
    next_cycle();
    rst = 1'b1;
    bus.req_valid = 3'b000;
    @(negedge clk);
    chk_reset_outputs("mr_t2");
    next_cycle();
    @(negedge clk);
    chk("mr_rspv_t3", 32'(bus.rsp_valid), 32'h0);
    next_cycle();

    // INT write with no byte enables still gets acknowledged
    idle_reqs();
    bus.req_valid = 3'b100; bus.req_we = 3'b100; bus.req_be = 12'h000;
    bus.req_data  = {32'hCAFEF00D, 64'h0};
    bus.req_tag   = {8'h77, 8'h21, 8'h10};
    @(negedge clk);
    chk("be0_ready", 32'(bus.req_ready), 32'h4);
    chk("be0_we",    32'(bram_we),       32'h0);
    next_cycle();
    bus.req_valid = 3'b000;
    @(negedge clk);
    chk("be0_we_t1", 32'(bram_we), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("be0_v",    32'(bus.rsp_valid), 32'h4);
    chk("be0_wr",   32'(bus.rsp_wr),    32'h1);
    chk("be0_tag",  32'(bus.rsp_tag),   32'h77);
    chk("be0_data", bus.rsp_data,       32'h0);
    chk("be0_mem",  mem[10'h300],       memval(32'h300));
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
